// File: rtl/cpu_pkg.sv
// Shared types and encodings for the CPU control path: FSM states, opcode
// classes, ALU operations and write-back source selects.
package cpu_pkg;

  typedef enum logic [2:0] {
    WAIT,
    DECODE,
    GET_A,
    GET_B,
    ALU,
    WRITE_REG,
    WRITE_IMM
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  typedef struct packed {
    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] shift;
    logic [2:0] rm;
    logic       is_mov_imm;
    logic       is_mov_reg;
    logic       is_alu;
    logic       is_cmp;
    logic       skip_a;
  } decode_t;

  function automatic logic [15:0] sext(input logic [15:0] v, input int unsigned bits);
    logic [15:0] r;
    r = v;
    for (int unsigned i = bits; i < 16; i++) r[i] = v[bits-1];
    return r;
  endfunction

endpackage

// File: rtl/cpu_instr_decoder.sv
// Combinational instruction decode: field slices, sign-extended immediates
// and opcode-class flags consumed by the control FSM.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output decode_t     dec,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  always_comb begin
    dec            = '0;
    dec.opcode     = ir[15:13];
    dec.op         = ir[12:11];
    dec.rn         = ir[10:8];
    dec.rd         = ir[7:5];
    dec.shift      = ir[4:3];
    dec.rm         = ir[2:0];
    dec.is_mov_imm = (ir[15:13] == OPC_MOV) && (ir[12:11] == OP_MOV_IMM);
    dec.is_mov_reg = (ir[15:13] == OPC_MOV) && (ir[12:11] == OP_MOV_REG);
    dec.is_alu     = (ir[15:13] == OPC_ALU);
    dec.is_cmp     = (ir[15:13] == OPC_ALU) && (ir[12:11] == ALU_CMP);
    // MOV reg and MVN are single-operand: they bypass the A-register fetch
    dec.skip_a     = dec.is_mov_reg || (dec.is_alu && (ir[12:11] == ALU_MVN));
  end

  assign sximm8 = sext({8'h00, ir[7:0]}, 8);
  assign sximm5 = sext({11'h000, ir[4:0]}, 5);

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore control FSM sequencing the register-file/ALU
// datapath strobes for one instruction per start pulse.
module cpu_controller
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s,
  input  logic        load,
  input  logic [15:0] in,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5
);

  state_t      state, next_state;
  logic [15:0] ir;
  decode_t     dec;

  instr_decoder u_dec (
    .ir     (ir),
    .dec    (dec),
    .sximm8 (sximm8),
    .sximm5 (sximm5)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (load && state == WAIT) ir <= in;
    end
  end

  assign shift = dec.shift;

  always_comb begin
    next_state = state;
    w          = 1'b0;
    readnum    = dec.rm;
    writenum   = dec.rd;
    write      = 1'b0;
    vsel       = VSEL_C;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    ALUop      = ALU_ADD;

    unique case (state)
      WAIT: begin
        w = 1'b1;
        if (s) next_state = DECODE;
      end
      DECODE: begin
        if (dec.is_mov_imm)  next_state = WRITE_IMM;
        else if (dec.skip_a) next_state = GET_B;
        else if (dec.is_alu) next_state = GET_A;
        else                 next_state = WAIT;
      end
      GET_A: begin
        readnum    = dec.rn;
        loada      = 1'b1;
        next_state = GET_B;
      end
      GET_B: begin
        loadb      = 1'b1;
        next_state = ALU;
      end
      ALU: begin
        if (dec.is_mov_reg) begin
          asel  = 1'b1;
          ALUop = ALU_ADD;
        end else begin
          ALUop = dec.op;
        end
        if (dec.is_cmp) begin
          loads      = 1'b1;
          next_state = WAIT;
        end else begin
          loadc      = 1'b1;
          next_state = WRITE_REG;
        end
      end
      WRITE_REG: begin
        vsel       = VSEL_C;
        write      = 1'b1;
        next_state = WAIT;
      end
      WRITE_IMM: begin
        writenum   = dec.rn;
        vsel       = VSEL_IMM;
        write      = 1'b1;
        next_state = WAIT;
      end
      default: next_state = WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: expected per-cycle control vectors are
// queued as each instruction is launched and popped on every falling edge.
module tb_cpu_controller;

  typedef logic [19:0] vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in = '0;
  logic        w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [1:0]  vsel, ALUop, shift;
  logic [15:0] sximm8, sximm5;

  int checks = 0;
  int failures = 0;
  vec_t exp_q[$];

  // input values applied just after the first edge of a launch
  logic s_after = 1'b0;
  logic load_after = 1'b0;

  cpu_controller dut (
    .clk(clk), .rst_n(rst_n), .s(s), .load(load), .in(in),
    .w(w), .readnum(readnum), .writenum(writenum), .write(write),
    .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .ALUop(ALUop),
    .shift(shift), .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(input logic ww, input logic [2:0] rn, input logic [2:0] wn,
                             input logic wr, input logic [1:0] vs, input logic la,
                             input logic lb, input logic lc, input logic ls,
                             input logic as, input logic [1:0] op, input logic [1:0] sh);
    return {ww, rn, wn, wr, vs, la, lb, lc, ls, as, 1'b0, op, sh};
  endfunction

  function automatic vec_t observed();
    return {w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
            asel, bsel, ALUop, shift};
  endfunction

  task automatic chk_vec(input string tag, input vec_t expv);
    vec_t obs;
    obs = observed();
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic pop_check(input string tag);
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s: observed=queue_empty expected=queue_entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk_vec(tag, e);
    end
  endtask

  // Launch: drive in/load/s before the edge, apply *_after once it passes,
  // then compare one queued vector per cycle until the queue drains.
  task automatic run(input string tag, input logic [15:0] instr, input logic ld);
    in   = instr;
    load = ld;
    s    = 1'b1;
    @(posedge clk);
    #1;
    s    = s_after;
    load = load_after;
    @(negedge clk);
    pop_check(tag);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      pop_check(tag);
    end
  endtask

  initial begin
    // reset state
    #2;
    chk_vec("reset", v(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    chk16("reset_sximm8", sximm8, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // IR=0 is undefined: DECODE then WAIT, no write
    exp_q.push_back(v(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    run("nop", 16'h0000, 1'b0);

    // MOV R0,#7
    exp_q.push_back(v(0, 7, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(0, 7, 0, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(1, 7, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    run("mov_imm7", 16'hD007, 1'b1);
    chk16("mov_imm7_sximm8", sximm8, 16'h0007);
    chk16("mov_imm7_sximm5", sximm5, 16'h0007);

    // MOV R1,#-2
    exp_q.push_back(v(0, 6, 7, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11));
    exp_q.push_back(v(0, 6, 1, 1, 2'b10, 0, 0, 0, 0, 0, 2'b00, 2'b11));
    exp_q.push_back(v(1, 6, 7, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11));
    run("mov_imm_m2", 16'hD1FE, 1'b1);
    chk16("mov_m2_sximm8", sximm8, 16'hFFFE);
    chk16("mov_m2_sximm5", sximm5, 16'hFFFE);

    // ADD R2,R1,R0 LSL#1
    exp_q.push_back(v(0, 0, 2, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01));
    exp_q.push_back(v(0, 1, 2, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b01));
    exp_q.push_back(v(0, 0, 2, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01));
    exp_q.push_back(v(0, 0, 2, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b01));
    exp_q.push_back(v(0, 0, 2, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01));
    exp_q.push_back(v(1, 0, 2, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01));
    run("add", 16'hA148, 1'b1);

    // CMP R1,R0
    exp_q.push_back(v(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(0, 0, 0, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(0, 0, 0, 0, 2'b00, 0, 0, 0, 1, 0, 2'b01, 2'b00));
    exp_q.push_back(v(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    run("cmp", 16'hA900, 1'b1);

    // MOV R3,R1 with load=1/in=FFFF held outside WAIT
    load_after = 1'b1;
    exp_q.push_back(v(0, 1, 3, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(0, 1, 3, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(0, 1, 3, 0, 2'b00, 0, 0, 1, 0, 1, 2'b00, 2'b00));
    exp_q.push_back(v(0, 1, 3, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(1, 1, 3, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    in = 16'hC061;
    fork
      begin
        @(posedge clk);
        #2 in = 16'hFFFF;
      end
    join_none
    run("mov_reg", 16'hC061, 1'b1);
    load_after = 1'b0;
    load = 1'b0;
    chk16("mov_reg_ir_kept", sximm8, 16'h0061);

    // MVN R7,R2
    exp_q.push_back(v(0, 2, 7, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(0, 2, 7, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(0, 2, 7, 0, 2'b00, 0, 0, 1, 0, 0, 2'b11, 2'b00));
    exp_q.push_back(v(0, 2, 7, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(1, 2, 7, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    run("mvn", 16'hB8E2, 1'b1);

    // AND R2,R4,R2 LSL#1 relaunched twice by a held start
    s_after = 1'b1;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(v(0, 2, 2, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01));
      exp_q.push_back(v(0, 4, 2, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b01));
      exp_q.push_back(v(0, 2, 2, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01));
      exp_q.push_back(v(0, 2, 2, 0, 2'b00, 0, 0, 1, 0, 0, 2'b10, 2'b01));
      exp_q.push_back(v(0, 2, 2, 1, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01));
      exp_q.push_back(v(1, 2, 2, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01));
    end
    run("and_held", 16'hB44A, 1'b1);
    s_after = 1'b0;
    s = 1'b0;
    @(negedge clk);
    chk_vec("and_idle", v(1, 2, 2, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01));

    // reset asserted in the ALU state of an ADD
    exp_q.push_back(v(0, 0, 2, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01));
    exp_q.push_back(v(0, 1, 2, 0, 2'b00, 1, 0, 0, 0, 0, 2'b00, 2'b01));
    exp_q.push_back(v(0, 0, 2, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 2'b01));
    exp_q.push_back(v(0, 0, 2, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 2'b01));
    run("add_pre_rst", 16'hA148, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk_vec("mid_reset", v(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    chk16("mid_reset_ir", sximm8, 16'h0000);
    @(posedge clk);
    #1;
    chk_vec("reset_hold", v(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.push_back(v(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    exp_q.push_back(v(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00));
    run("post_reset_nop", 16'h0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
